// File: rtl/led_status_bank.sv
// Per-channel LED driver: off/on/PWM/heartbeat/activity modes,
// configured and read back over the local bus.
module led_status_bank #(
  parameter int N_LED = 8,
  parameter int PWM_W = 8,
  parameter int HB_DIV = 26,
  parameter int STRETCH_CYC = 1250000,
  parameter int ADDR_W = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 24'h020000,
  parameter int DEFAULT_MODE = 3
) (
  input  logic              lb_clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lb_addr,
  input  logic              lb_write,
  input  logic              lb_rd,
  input  logic [31:0]       lb_data,
  output logic [31:0]       lb_rdata,
  output logic              lb_rd_valid,
  input  logic [N_LED-1:0]  act_in,
  output logic [N_LED-1:0]  led_out
);

  localparam int SW = (STRETCH_CYC < 1) ? 1
                    : $clog2(STRETCH_CYC + 1);
  localparam logic [SW-1:0] S_LOAD = SW'(STRETCH_CYC);
  localparam logic [2:0] M_RST = 3'(DEFAULT_MODE);

  logic [2:0]       mode    [N_LED];
  logic [PWM_W-1:0] duty    [N_LED];
  logic [SW-1:0]    stretch [N_LED];
  logic             invert;
  logic             lamp_test;
  logic [PWM_W-1:0] pwm_cnt;
  logic [HB_DIV-1:0] hb_cnt;

  logic [ADDR_W-1:0] off;
  logic              glob_hit;
  logic [31:0]       rd_word;
  logic [N_LED-1:0]  mode_val;
  logic              unused_ok;

  // Addresses below BASE_ADDR wrap to huge offsets and miss.
  assign off       = lb_addr - BASE_ADDR;
  assign glob_hit  = (off == ADDR_W'(N_LED));
  assign unused_ok = ^lb_data;

  always_comb begin
    rd_word = 32'd0;
    for (int i = 0; i < N_LED; i++) begin
      if (off == ADDR_W'(i)) begin
        rd_word = 32'(mode[i])
                | (32'(duty[i]) << 8);
      end
    end
    if (glob_hit) begin
      rd_word = {30'd0, lamp_test, invert};
    end
  end

  always_comb begin
    mode_val = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (mode[i])
        3'd1:    mode_val[i] = 1'b1;
        3'd2:    mode_val[i] = pwm_cnt < duty[i];
        3'd3:    mode_val[i] = hb_cnt[HB_DIV-1];
        3'd4:    mode_val[i] = stretch[i] != '0;
        default: mode_val[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LED; i++) begin
        mode[i]    <= M_RST;
        duty[i]    <= '0;
        stretch[i] <= '0;
      end
      invert      <= 1'b0;
      lamp_test   <= 1'b0;
      pwm_cnt     <= '0;
      hb_cnt      <= '0;
      led_out     <= '0;
      lb_rdata    <= 32'd0;
      lb_rd_valid <= 1'b0;
    end else begin
      pwm_cnt     <= pwm_cnt + 1'b1;
      hb_cnt      <= hb_cnt + 1'b1;
      lb_rd_valid <= lb_rd;
      if (lb_rd) begin
        lb_rdata <= rd_word;
      end
      for (int i = 0; i < N_LED; i++) begin
        if (lb_write && off == ADDR_W'(i)) begin
          mode[i] <= lb_data[2:0];
          duty[i] <= lb_data[PWM_W+7:8];
        end
        // Stretch runs in every mode so a mode switch shows remaining time.
        if (act_in[i]) begin
          stretch[i] <= S_LOAD;
        end else if (stretch[i] != '0) begin
          stretch[i] <= stretch[i] - 1'b1;
        end
      end
      if (lb_write && glob_hit) begin
        invert    <= lb_data[0];
        lamp_test <= lb_data[1];
      end
      led_out <= (lamp_test ? {N_LED{1'b1}} : mode_val)
               ^ {N_LED{invert}};
    end
  end

endmodule
